// File: rtl/alu_req_scheduler.sv
// -----------------------------------------------------------------------------
// alu_req_scheduler
//
// Shares a single ALU core between NUM_REQ requesters. Requesters are served
// round-robin. Each accepted transaction carries one 8-bit command and two
// operands. Commands outside the legal set are answered directly with
// INVALID_COMMAND. NOP is answered directly with NO_ERROR. Every other legal
// command is issued to the ALU, and the scheduler then waits for completion,
// giving up after TIMEOUT_CYCLES wait cycles with MISSING_DATA. The answer
// returns on one response channel that is tagged with the requester index.
//
// Ports
//   clk, rst          clock and synchronous active-high reset
//   req_valid/ready   per-requester handshake; ready is one-hot or zero
//   req_cmd/a/b       packed per-requester command and operands
//   alu_start         one-cycle issue strobe towards the ALU
//   alu_cmd/a/b       command and operands; held until the next issue
//   alu_done          ALU completion strobe (sampled only while waiting)
//   alu_result/status ALU result and status, valid with alu_done
//   rsp_valid/ready   response handshake
//   rsp_id            index of the requester being answered
//   rsp_result/status response payload, held stable until accepted
//   busy              high whenever the scheduler is not idle
// -----------------------------------------------------------------------------
module alu_req_scheduler #(
  parameter int NUM_REQ        = 2,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic [NUM_REQ-1:0]                             req_valid,
  output logic [NUM_REQ-1:0]                             req_ready,
  input  logic [NUM_REQ*8-1:0]                           req_cmd,
  input  logic [NUM_REQ*DATA_W-1:0]                      req_a,
  input  logic [NUM_REQ*DATA_W-1:0]                      req_b,
  output logic                                           alu_start,
  output logic [7:0]                                     alu_cmd,
  output logic [DATA_W-1:0]                              alu_a,
  output logic [DATA_W-1:0]                              alu_b,
  input  logic                                           alu_done,
  input  logic [DATA_W-1:0]                              alu_result,
  input  logic [7:0]                                     alu_status,
  output logic                                           rsp_valid,
  input  logic                                           rsp_ready,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] rsp_id,
  output logic [DATA_W-1:0]                              rsp_result,
  output logic [7:0]                                     rsp_status,
  output logic                                           busy
);

  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [7:0] CMD_NOP = 8'h00;
  localparam logic [7:0] CMD_AND = 8'h01;
  localparam logic [7:0] CMD_OR  = 8'h02;
  localparam logic [7:0] CMD_XOR = 8'h03;
  localparam logic [7:0] CMD_ADD = 8'h10;
  localparam logic [7:0] CMD_SUB = 8'h20;

  localparam logic [7:0] STAT_NO_ERROR        = 8'h00;
  localparam logic [7:0] STAT_MISSING_DATA    = 8'h01;
  localparam logic [7:0] STAT_INVALID_COMMAND = 8'h80;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

  // Commands that must go through the ALU (legal and not NOP).
  function automatic logic is_alu_cmd(input logic [7:0] c);
    return (c == CMD_AND) || (c == CMD_OR) || (c == CMD_XOR) ||
           (c == CMD_ADD) || (c == CMD_SUB);
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [7:0]          alu_cmd_q, alu_cmd_d;
  logic [DATA_W-1:0]   alu_a_q, alu_a_d;
  logic [DATA_W-1:0]   alu_b_q, alu_b_d;
  logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0]   rsp_result_q, rsp_result_d;
  logic [7:0]          rsp_status_q, rsp_status_d;

  // ---------------------------------------------------------------------------
  // Unpack the per-requester buses
  // ---------------------------------------------------------------------------
  logic [7:0]        cmd_arr [NUM_REQ];
  logic [DATA_W-1:0] a_arr   [NUM_REQ];
  logic [DATA_W-1:0] b_arr   [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign cmd_arr[gi] = req_cmd[8*gi +: 8];
    assign a_arr[gi]   = req_a[DATA_W*gi +: DATA_W];
    assign b_arr[gi]   = req_b[DATA_W*gi +: DATA_W];
  end

  // ---------------------------------------------------------------------------
  // Round-robin grant: first valid requester at or above ptr_q, with wrap.
  // The loop walks candidates in priority order and keeps the first hit.
  // ---------------------------------------------------------------------------
  logic            grant_found;
  logic [ID_W-1:0] grant_idx;
  logic [ID_W-1:0] grant_cand;
  int              grant_sum;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    grant_cand  = '0;
    grant_sum   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      grant_sum = int'(ptr_q) + k;
      if (grant_sum >= NUM_REQ) begin
        grant_sum = grant_sum - NUM_REQ;
      end
      grant_cand = ID_W'(grant_sum);
      if (!grant_found && req_valid[grant_cand]) begin
        grant_found = 1'b1;
        grant_idx   = grant_cand;
      end
    end
  end

  logic [7:0] grant_cmd;
  assign grant_cmd = cmd_arr[grant_idx];

  // Accept strobe exists only in IDLE, so a response handshake cycle can
  // never coincide with a new accept.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
    assign req_ready[gi] = (state_q == ST_IDLE) && grant_found &&
                           (grant_idx == ID_W'(gi));
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    alu_cmd_d    = alu_cmd_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_status_d = rsp_status_q;

    unique case (state_q)
      ST_IDLE: begin
        if (grant_found) begin
          ptr_d    = (grant_idx == ID_LAST) ? '0 : grant_idx + 1'b1;
          rsp_id_d = grant_idx;
          if (is_alu_cmd(grant_cmd)) begin
            // The ALU-facing registers are loaded only for real issues so
            // they keep their last issued values across NOP/invalid requests.
            alu_cmd_d = grant_cmd;
            alu_a_d   = a_arr[grant_idx];
            alu_b_d   = b_arr[grant_idx];
            state_d   = ST_ISSUE;
          end else begin
            rsp_result_d = '0;
            rsp_status_d = (grant_cmd == CMD_NOP) ? STAT_NO_ERROR
                                                  : STAT_INVALID_COMMAND;
            state_d      = ST_RESP;
          end
        end
      end

      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        // alu_done is checked first so it wins in the terminal cycle.
        if (alu_done) begin
          rsp_result_d = alu_result;
          rsp_status_d = alu_status;
          state_d      = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          rsp_result_d = '0;
          rsp_status_d = STAT_MISSING_DATA;
          state_d      = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      cnt_q        <= '0;
      alu_cmd_q    <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_status_q <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      alu_cmd_q    <= alu_cmd_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_status_q <= rsp_status_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign alu_start  = (state_q == ST_ISSUE);
  assign alu_cmd    = alu_cmd_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign rsp_valid  = (state_q == ST_RESP);
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_status = rsp_status_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_req_scheduler.sv
// -----------------------------------------------------------------------------
// tb_alu_req_scheduler
//
// Directed bench for alu_req_scheduler (NUM_REQ=2, DATA_W=32,
// TIMEOUT_CYCLES=64). A table of single-requester transactions is replayed
// in a loop; hand-written sequences cover arbitration, timeout, response
// back-pressure and reset in the middle of an operation.
// The ALU model raises alu_done in the second cycle after the start cycle
// (start in T+1, done in T+3, so rsp_valid in T+4) unless alu_never is set.
// -----------------------------------------------------------------------------
module tb_alu_req_scheduler;
  localparam int NR = 2;
  localparam int DW = 32;
  localparam int TO = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_ready;
  logic [NR*8-1:0] req_cmd;
  logic [NR*DW-1:0] req_a;
  logic [NR*DW-1:0] req_b;
  logic            alu_start;
  logic [7:0]      alu_cmd;
  logic [DW-1:0]   alu_a;
  logic [DW-1:0]   alu_b;
  logic            alu_done;
  logic [DW-1:0]   alu_result;
  logic [7:0]      alu_status;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [0:0]      rsp_id;
  logic [DW-1:0]   rsp_result;
  logic [7:0]      rsp_status;
  logic            busy;

  alu_req_scheduler #(
    .NUM_REQ       (NR),
    .DATA_W        (DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_cmd   (req_cmd),
    .req_a     (req_a),
    .req_b     (req_b),
    .alu_start (alu_start),
    .alu_cmd   (alu_cmd),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_done  (alu_done),
    .alu_result(alu_result),
    .alu_status(alu_status),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_result(rsp_result),
    .rsp_status(rsp_status),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // ALU model
  // ---------------------------------------------------------------------------
  logic          alu_never;
  logic          man_done;
  logic [7:0]    cfg_status;
  logic          model_pend;
  logic          model_done;
  logic [DW-1:0] model_res;

  always @(posedge clk) begin
    if (rst) begin
      model_pend <= 1'b0;
      model_done <= 1'b0;
      model_res  <= '0;
    end else begin
      model_done <= 1'b0;
      if (alu_start && !alu_never) begin
        model_pend <= 1'b1;
        case (alu_cmd)
          8'h01:   model_res <= alu_a & alu_b;
          8'h02:   model_res <= alu_a | alu_b;
          8'h03:   model_res <= alu_a ^ alu_b;
          8'h10:   model_res <= alu_a + alu_b;
          8'h20:   model_res <= alu_a - alu_b;
          default: model_res <= 32'hBAD0_BAD0;
        endcase
      end else if (model_pend) begin
        model_pend <= 1'b0;
        model_done <= 1'b1;
      end
    end
  end

  assign alu_done   = model_done | man_done;
  assign alu_result = model_res;
  assign alu_status = cfg_status;

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Leaves the bench 2 time units after a rising edge (drive point).
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"},  64'(req_ready),  64'(0));
    chk({tag, "_alu_start"},  64'(alu_start),  64'(0));
    chk({tag, "_rsp_valid"},  64'(rsp_valid),  64'(0));
    chk({tag, "_busy"},       64'(busy),       64'(0));
    chk({tag, "_alu_cmd"},    64'(alu_cmd),    64'(0));
    chk({tag, "_alu_a"},      64'(alu_a),      64'(0));
    chk({tag, "_alu_b"},      64'(alu_b),      64'(0));
    chk({tag, "_rsp_id"},     64'(rsp_id),     64'(0));
    chk({tag, "_rsp_result"}, 64'(rsp_result), 64'(0));
    chk({tag, "_rsp_status"}, 64'(rsp_status), 64'(0));
  endtask

  // Called at the drive point; returns at the sample point of the accept cycle.
  task automatic wait_grant(output int gid, output int t);
    gid = -1;
    t   = 0;
    for (int n = 0; n < 50; n++) begin
      #1;
      chk("ready_onehot0", 64'($onehot0(req_ready)), 64'(1));
      if (req_ready != '0) begin
        for (int i = 0; i < NR; i++) begin
          if (req_ready[i]) gid = i;
        end
        t = cyc;
        return;
      end
      @(posedge clk);
      #2;
    end
    checks++;
    failures++;
    $display("FAIL grant_timeout: got=no grant expected=grant within 50 cycles");
  endtask

  // Called at the drive point of T+1; returns at the sample point of the
  // first rsp_valid cycle, counting alu_start pulses on the way.
  task automatic wait_rsp(input int t, output int lat, output int starts,
                          output logic [7:0] scmd, output logic [DW-1:0] sa,
                          output logic [DW-1:0] sb);
    lat    = -1;
    starts = 0;
    scmd   = '0;
    sa     = '0;
    sb     = '0;
    for (int n = 0; n < 200; n++) begin
      #1;
      if (alu_start) begin
        starts++;
        scmd = alu_cmd;
        sa   = alu_a;
        sb   = alu_b;
      end
      if (rsp_valid) begin
        lat = cyc - t;
        return;
      end
      @(posedge clk);
      #2;
    end
    checks++;
    failures++;
    $display("FAIL rsp_timeout: got=no rsp_valid expected=rsp_valid within 200 cycles");
  endtask

  // Called at a sample point with rsp_valid high; completes the handshake.
  task automatic ack();
    rsp_ready = 1'b1;
    @(posedge clk);
    #2;
    rsp_ready = 1'b0;
  endtask

  typedef struct {
    int            id;
    logic [7:0]    cmd;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [7:0]    mstat;   // status the ALU model returns
    int            starts;  // expected alu_start pulses
    logic [DW-1:0] res;
    logic [7:0]    stat;
    int            lat;     // rsp_valid cycle minus accept cycle
  } vec_t;

  task automatic run_vec(input vec_t v);
    int            gid, t, lat, starts;
    logic [7:0]    scmd;
    logic [DW-1:0] sa, sb;
    cfg_status = v.mstat;
    req_cmd[8*v.id +: 8] = v.cmd;
    req_a[DW*v.id +: DW] = v.a;
    req_b[DW*v.id +: DW] = v.b;
    req_valid[v.id]      = 1'b1;
    wait_grant(gid, t);
    chk("grant_id", 64'(gid), 64'(v.id));
    tick();
    // Inputs after the accept cycle must not matter.
    req_valid[v.id]      = 1'b0;
    req_cmd[8*v.id +: 8] = 8'h01;
    req_a[DW*v.id +: DW] = 32'hDEAD_BEEF;
    req_b[DW*v.id +: DW] = 32'h0;
    wait_rsp(t, lat, starts, scmd, sa, sb);
    chk("alu_start_count", 64'(starts), 64'(v.starts));
    if (v.starts > 0) begin
      chk("alu_cmd", 64'(scmd), 64'(v.cmd));
      chk("alu_a",   64'(sa),   64'(v.a));
      chk("alu_b",   64'(sb),   64'(v.b));
    end
    chk("latency",    64'(lat),        64'(v.lat));
    chk("rsp_id",     64'(rsp_id),     64'(v.id));
    chk("rsp_result", 64'(rsp_result), 64'(v.res));
    chk("rsp_status", 64'(rsp_status), 64'(v.stat));
    $display("txn req=%0d cmd=%02h a=%08h b=%08h -> id=%0d result=%08h status=%02h lat=%0d starts=%0d",
             v.id, v.cmd, v.a, v.b, rsp_id, rsp_result, rsp_status, lat, starts);
    ack();
  endtask

  vec_t vecs [11];
  vec_t tov;

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int            gid, t, lat, starts;
    logic [7:0]    scmd;
    logic [DW-1:0] sa, sb;

    rst        = 1'b1;
    req_valid  = '0;
    req_cmd    = '0;
    req_a      = '0;
    req_b      = '0;
    rsp_ready  = 1'b0;
    man_done   = 1'b0;
    alu_never  = 1'b0;
    cfg_status = 8'h00;

    //            id cmd    a             b             mstat st res           stat   lat
    vecs[0]  = '{0, 8'h10, 32'd5,        32'd7,        8'h00, 1, 32'd12,       8'h00, 4};
    vecs[1]  = '{1, 8'h55, 32'h1234_5678, 32'h9ABC_DEF0, 8'h00, 0, 32'd0,        8'h80, 1};
    vecs[2]  = '{0, 8'h00, 32'd9,        32'd9,        8'h00, 0, 32'd0,        8'h00, 1};
    vecs[3]  = '{1, 8'h01, 32'hF0F0_1234, 32'h0FF0_00FF, 8'h00, 1, 32'h00F0_0034, 8'h00, 4};
    vecs[4]  = '{0, 8'h02, 32'h1200_0000, 32'h0000_0034, 8'h00, 1, 32'h1200_0034, 8'h00, 4};
    vecs[5]  = '{1, 8'h20, 32'd10,       32'd3,        8'h00, 1, 32'd7,        8'h00, 4};
    vecs[6]  = '{0, 8'h20, 32'd3,        32'd5,        8'h00, 1, 32'hFFFF_FFFE, 8'h00, 4};
    vecs[7]  = '{1, 8'h10, 32'hFFFF_FFFF, 32'd1,        8'h00, 1, 32'd0,        8'h00, 4};
    vecs[8]  = '{0, 8'h04, 32'd1,        32'd2,        8'h00, 0, 32'd0,        8'h80, 1};
    vecs[9]  = '{1, 8'hFF, 32'd1,        32'd2,        8'h00, 0, 32'd0,        8'h80, 1};
    vecs[10] = '{0, 8'h03, 32'hAAAA_5555, 32'hFFFF_0000, 8'h42, 1, 32'h5555_5555, 8'h42, 4};

    // Power-on reset state.
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("reset");
    tick();

    // Table-driven single-requester transactions.
    for (int i = 0; i < 11; i++) begin
      run_vec(vecs[i]);
    end

    // Round-robin with both requesters holding req_valid.
    do_reset();
    cfg_status       = 8'h00;
    req_cmd[0 +: 8]  = 8'h03;
    req_a[0 +: DW]   = 32'h0000_000F;
    req_b[0 +: DW]   = 32'h0000_00F0;
    req_cmd[8 +: 8]  = 8'h03;
    req_a[DW +: DW]  = 32'h0000_0033;
    req_b[DW +: DW]  = 32'h0000_000F;
    req_valid        = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wait_grant(gid, t);
      chk("rr_grant", 64'(gid), 64'(i % 2));
      tick();
      wait_rsp(t, lat, starts, scmd, sa, sb);
      chk("rr_rsp_id", 64'(rsp_id), 64'(i % 2));
      chk("rr_result", 64'(rsp_result), (i % 2 == 0) ? 64'h0000_00FF : 64'h0000_003C);
      $display("txn rr#%0d grant=%0d -> id=%0d result=%08h status=%02h lat=%0d",
               i, gid, rsp_id, rsp_result, rsp_status, lat);
      ack();
    end
    req_valid = '0;

    // Timeout: SUB with an ALU that never finishes (64 WAIT cycles).
    alu_never = 1'b1;
    tov = '{1, 8'h20, 32'd20, 32'd5, 8'h00, 1, 32'd0, 8'h01, TO + 2};
    run_vec(tov);
    alu_never = 1'b0;
    // Late alu_done while idle must be ignored.
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    #1;
    chk("late_done_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("late_done_busy",      64'(busy),      64'(0));
    tick();
    run_vec(vecs[0]);

    // Response back-pressure for 10 cycles after an AND.
    cfg_status      = 8'h00;
    req_cmd[0 +: 8] = 8'h01;
    req_a[0 +: DW]  = 32'h0000_00FF;
    req_b[0 +: DW]  = 32'h0000_000F;
    req_valid[0]    = 1'b1;
    wait_grant(gid, t);
    chk("bp_grant", 64'(gid), 64'(0));
    tick();
    req_valid[0]    = 1'b0;
    req_cmd[8 +: 8] = 8'h02;
    req_valid[1]    = 1'b1;   // a waiting requester must not be accepted
    wait_rsp(t, lat, starts, scmd, sa, sb);
    chk("bp_latency", 64'(lat), 64'(4));
    for (int i = 0; i < 10; i++) begin
      tick();
      #1;
      chk("bp_rsp_valid",  64'(rsp_valid),  64'(1));
      chk("bp_rsp_id",     64'(rsp_id),     64'(0));
      chk("bp_rsp_result", 64'(rsp_result), 64'h0000_000F);
      chk("bp_rsp_status", 64'(rsp_status), 64'(0));
      chk("bp_req_ready",  64'(req_ready),  64'(0));
      chk("bp_busy",       64'(busy),       64'(1));
    end
    $display("txn bp req=0 cmd=01 -> id=%0d result=%08h status=%02h held 10 cycles",
             rsp_id, rsp_result, rsp_status);
    ack();
    req_valid = '0;

    // Reset during WAIT, then a stray alu_done two cycles after release.
    alu_never       = 1'b1;
    req_cmd[0 +: 8] = 8'h20;
    req_a[0 +: DW]  = 32'h0000_0100;
    req_b[0 +: DW]  = 32'h0000_0001;
    req_valid[0]    = 1'b1;
    wait_grant(gid, t);
    chk("rstw_grant", 64'(gid), 64'(0));
    tick();
    req_valid = '0;
    tick();
    tick();
    #1;
    chk("rstw_in_wait_busy", 64'(busy), 64'(1));
    #1;
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("rstw");
    #1;
    tick();
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rstw_no_rsp",  64'(rsp_valid), 64'(0));
      chk("rstw_idle",    64'(busy),      64'(0));
      tick();
    end
    alu_never       = 1'b0;
    req_cmd[8 +: 8] = 8'h03;
    req_a[DW +: DW] = 32'h0000_0001;
    req_b[DW +: DW] = 32'h0000_0002;
    req_valid       = 2'b11;
    wait_grant(gid, t);
    chk("rstw_first_grant", 64'(gid), 64'(0));
    tick();
    req_valid = '0;
    wait_rsp(t, lat, starts, scmd, sa, sb);
    chk("rstw_rsp_id",     64'(rsp_id),     64'(0));
    chk("rstw_rsp_result", 64'(rsp_result), 64'h0000_00FF);
    chk("rstw_rsp_status", 64'(rsp_status), 64'(0));
    $display("txn post-reset grant=%0d -> id=%0d result=%08h status=%02h lat=%0d",
             gid, rsp_id, rsp_result, rsp_status, lat);
    ack();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog: got=still running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
